// File: rtl/ea_calc_pkg.sv
// Shared definitions for the KS-10 effective-address calculator:
// state encodings, instruction field positions, EA width and decode helpers.
package ea_calc_pkg;

  localparam int EA_W  = 18;
  localparam int I_BIT = 13;
  localparam int X_MSB = 14;
  localparam int X_LSB = 17;
  localparam int Y_MSB = 18;
  localparam int Y_LSB = 35;

  typedef logic [0:35]         word_t;
  typedef logic [18:35]        ea_t;
  typedef logic [X_MSB:X_LSB]  xnum_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INDEX = 2'd1,
    S_INDIR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic f_ind(input word_t w);
    return w[I_BIT];
  endfunction

  function automatic xnum_t f_x(input word_t w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic ea_t f_y(input word_t w);
    return w[Y_MSB:Y_LSB];
  endfunction

  // Branch taken after a word's I/X/Y fields are known; a pending interrupt
  // diverts what would have been an indirect fetch straight to DONE.
  function automatic state_t branch(input logic ind, input xnum_t x, input logic irq);
    if (x != 4'd0)
      return S_INDEX;
    else if (ind && !irq)
      return S_INDIR;
    else
      return S_DONE;
  endfunction

  function automatic logic diverts(input logic ind, input xnum_t x, input logic irq);
    return ind && (x == 4'd0) && irq;
  endfunction

endpackage

// File: rtl/ea_calc_if.sv
// Bus bundle between the EA calculator (master) and its CPU surroundings
// (slave): start/instruction word, index-register and memory handshakes, status.
interface ea_calc_if;
  import ea_calc_pkg::*;

  logic   start;
  word_t  dbus;
  logic   xreg_req;
  xnum_t  xreg_num;
  logic   xreg_ack;
  word_t  xreg_data;
  logic   mem_req;
  ea_t    mem_addr;
  logic   mem_ack;
  logic   mem_nxm;
  word_t  mem_data;
  logic   intr;
  logic   busy;
  logic   done;
  ea_t    ea;
  logic   ea_err;
  logic   ea_intr;

  modport master (
    input  start, dbus, xreg_ack, xreg_data, mem_ack, mem_nxm, mem_data, intr,
    output xreg_req, xreg_num, mem_req, mem_addr, busy, done, ea, ea_err, ea_intr
  );

  modport slave (
    output start, dbus, xreg_ack, xreg_data, mem_ack, mem_nxm, mem_data, intr,
    input  xreg_req, xreg_num, mem_req, mem_addr, busy, done, ea, ea_err, ea_intr
  );

endinterface

// File: rtl/ea_calc.sv
// PDP-10 section-zero effective-address calculator (index add + indirect chain).
// Optional interrupt abort of indirect chains is enabled by KS10_EA_INTR_EN.
module ea_calc
  import ea_calc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clken,
  ea_calc_if.master bus
);

  state_t state, state_nxt;
  ea_t    ea_q, ea_nxt;
  logic   ind_q, ind_nxt;
  xnum_t  x_q, x_nxt;
  logic   err_q, err_nxt;
  logic   intr_q, intr_nxt;
  logic   irq;
  logic   unused_bits;

`ifdef KS10_EA_INTR_EN
  assign irq = bus.intr;
  assign unused_bits = ^{bus.xreg_data[0:17], bus.mem_data[0:12], bus.dbus[0:12]};
`else
  assign irq = 1'b0;
  assign unused_bits = ^{bus.xreg_data[0:17], bus.mem_data[0:12], bus.dbus[0:12], bus.intr};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q   <= '0;
      ind_q  <= 1'b0;
      x_q    <= '0;
      err_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ea_q   <= ea_nxt;
      ind_q  <= ind_nxt;
      x_q    <= x_nxt;
      err_q  <= err_nxt;
      intr_q <= intr_nxt;
    end
  end

  // With clken low everything holds, so every transition is gated by it here.
  always_comb begin
    state_nxt = state;
    ea_nxt    = ea_q;
    ind_nxt   = ind_q;
    x_nxt     = x_q;
    err_nxt   = err_q;
    intr_nxt  = intr_q;
    if (clken) begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            ind_nxt   = f_ind(bus.dbus);
            x_nxt     = f_x(bus.dbus);
            ea_nxt    = f_y(bus.dbus);
            err_nxt   = 1'b0;
            intr_nxt  = diverts(f_ind(bus.dbus), f_x(bus.dbus), irq);
            state_nxt = branch(f_ind(bus.dbus), f_x(bus.dbus), irq);
          end
        end
        S_INDEX: begin
          if (bus.xreg_ack) begin
            ea_nxt    = ea_q + f_y(bus.xreg_data);
            intr_nxt  = diverts(ind_q, 4'd0, irq);
            state_nxt = branch(ind_q, 4'd0, irq);
          end
        end
        S_INDIR: begin
          if (bus.mem_ack) begin
            if (bus.mem_nxm) begin
              err_nxt   = 1'b1;
              state_nxt = S_DONE;
            end else begin
              ind_nxt   = f_ind(bus.mem_data);
              x_nxt     = f_x(bus.mem_data);
              ea_nxt    = f_y(bus.mem_data);
              intr_nxt  = diverts(f_ind(bus.mem_data), f_x(bus.mem_data), irq);
              state_nxt = branch(f_ind(bus.mem_data), f_x(bus.mem_data), irq);
            end
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // done is qualified by clken so a stalled DONE state still yields one pulse.
  assign bus.xreg_req = (state == S_INDEX);
  assign bus.xreg_num = x_q;
  assign bus.mem_req  = (state == S_INDIR);
  assign bus.mem_addr = ea_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE) && clken;
  assign bus.ea       = ea_q;
  assign bus.ea_err   = err_q;
  assign bus.ea_intr  = intr_q;

endmodule
